// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit seven-segment scan driver with frame-latched value,
// per-slot anti-ghosting blank window and optional leading-zero suppression.
module seg_scan_driver #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        lz_blank,
  output logic [3:0]  bcd_enable,
  output logic [6:0]  bcd_signal,
  output logic        frame_done
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PH_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] PH_BLANK = PW'(BLANK_CYCLES);

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    case (nib)
      4'h0: return 7'h3F;
      4'h1: return 7'h06;
      4'h2: return 7'h5B;
      4'h3: return 7'h4F;
      4'h4: return 7'h66;
      4'h5: return 7'h6D;
      4'h6: return 7'h7D;
      4'h7: return 7'h07;
      4'h8: return 7'h7F;
      4'h9: return 7'h6F;
      4'hA: return 7'h77;
      4'hB: return 7'h7C;
      4'hC: return 7'h39;
      4'hD: return 7'h5E;
      4'hE: return 7'h79;
      4'hF: return 7'h71;
      default: return 7'h00;
    endcase
  endfunction

  // A slot is dark when its nibble and every nibble to its left are zero; slot 3 always shows.
  function automatic logic lz_suppressed(input logic [15:0] v, input logic [1:0] s);
    case (s)
      2'd0:    return (v[15:12] == 4'h0);
      2'd1:    return (v[15:8] == 8'h00);
      2'd2:    return (v[15:4] == 12'h000);
      default: return 1'b0;
    endcase
  endfunction

  logic [PW-1:0] phase_q, phase_d;
  logic [1:0]    slot_q, slot_d;
  logic [15:0]   pending_q, pending_d;
  logic [15:0]   shadow_q, shadow_d;
  logic          lz_q, lz_d;
  logic [3:0]    en_q, en_d;
  logic [6:0]    seg_q, seg_d;
  logic          done_q, done_d;
  logic          phase_wrap_s, frame_end_s;
  logic [3:0]    nib_s;

  // Next-state: outputs are computed for the upcoming cycle so the registers hold exact per-cycle values.
  always_comb begin
    phase_wrap_s = (phase_q == PH_LAST);
    frame_end_s  = phase_wrap_s && (slot_q == 2'd3);
    phase_d      = phase_wrap_s ? {PW{1'b0}} : phase_q + PW'(1);
    slot_d       = phase_wrap_s ? slot_q + 2'd1 : slot_q;
    pending_d    = load ? value : pending_q;
    shadow_d     = shadow_q;
    lz_d         = lz_q;
    if (frame_end_s) begin
      shadow_d = load ? value : pending_q;
      lz_d     = lz_blank;
    end else begin
      shadow_d = shadow_q;
      lz_d     = lz_q;
    end
    case (slot_d)
      2'd0:    nib_s = shadow_d[15:12];
      2'd1:    nib_s = shadow_d[11:8];
      2'd2:    nib_s = shadow_d[7:4];
      default: nib_s = shadow_d[3:0];
    endcase
    if ((phase_d < PH_BLANK) || (lz_d && lz_suppressed(shadow_d, slot_d))) begin
      en_d  = 4'b0000;
      seg_d = 7'h00;
    end else begin
      en_d  = 4'b0001 << slot_d;
      seg_d = hex7(nib_s);
    end
    done_d = (slot_d == 2'd3) && (phase_d == PH_LAST);
  end

  // State and output registers.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      phase_q   <= {PW{1'b0}};
      slot_q    <= 2'd0;
      pending_q <= 16'h0000;
      shadow_q  <= 16'h0000;
      lz_q      <= 1'b0;
      en_q      <= 4'b0000;
      seg_q     <= 7'h00;
      done_q    <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      slot_q    <= slot_d;
      pending_q <= pending_d;
      shadow_q  <= shadow_d;
      lz_q      <= lz_d;
      en_q      <= en_d;
      seg_q     <= seg_d;
      done_q    <= done_d;
    end
  end

  assign bcd_enable = en_q;
  assign bcd_signal = seg_q;
  assign frame_done = done_q;

endmodule
